// File: rtl/peak_search_multibin_if.sv
`default_nettype none
// =============================================================================
// peak_search_multibin_if: control, RAM read and result bus of the peak search (rev 1.0)
// =============================================================================
interface peak_search_multibin_if #(
  parameter int DATA_W   = 32,
  parameter int PTS_LOG2 = 10,
  parameter int BIN_W    = 4
) ();
  logic                      start;
  logic [PTS_LOG2-1:0]       win_lo;
  logic [PTS_LOG2-1:0]       win_hi;
  logic [DATA_W-1:0]         threshold;
  logic                      rd_en;
  logic [BIN_W+PTS_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;
  logic                      pk_valid;
  logic [BIN_W-1:0]          pk_bin;
  logic [PTS_LOG2-1:0]       pk_index;
  logic [DATA_W-1:0]         pk_value;
  logic [DATA_W-1:0]         pk_left;
  logic [DATA_W-1:0]         pk_right;
  logic                      pk_below_thr;
  logic                      done;
  logic                      cfg_err;

  modport master (
    input  start, win_lo, win_hi, threshold, rd_data,
    output rd_en, rd_addr, busy, pk_valid, pk_bin, pk_index, pk_value,
           pk_left, pk_right, pk_below_thr, done, cfg_err
  );

  modport slave (
    output start, win_lo, win_hi, threshold, rd_data,
    input  rd_en, rd_addr, busy, pk_valid, pk_bin, pk_index, pk_value,
           pk_left, pk_right, pk_below_thr, done, cfg_err
  );
endinterface
`default_nettype wire

// File: rtl/peak_search_multibin.sv
`default_nettype none
// =============================================================================
// peak_search_multibin: windowed per-range-bin peak search over external RAM (rev 1.0)
// =============================================================================
module peak_search_multibin #(
  parameter int DATA_W     = 32,
  parameter int NUM_BINS   = 9,
  parameter int PTS_LOG2   = 10,
  parameter int BIN_W      = 4,
  parameter int RD_LATENCY = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  peak_search_multibin_if.master bus
);
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0]    C_DRAIN_LAST = CW'(RD_LATENCY - 1);
  localparam logic [BIN_W-1:0] C_BIN_LAST   = BIN_W'(NUM_BINS - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                vld;
    logic [BIN_W-1:0]    bin;
    logic [PTS_LOG2-1:0] pt;
    logic                first;
    logic                last;
  } tag_t;

  state_t              state, state_nx;
  logic [PTS_LOG2-1:0] r_lo, r_hi, r_pt;
  logic [BIN_W-1:0]    r_bin;
  logic [DATA_W-1:0]   r_thr;
  logic [CW-1:0]       r_cnt;
  logic                r_err, r_done;
  tag_t                r_tag [RD_LATENCY];

  logic [DATA_W-1:0]   r_max, r_left, r_right, r_prev;
  logic [PTS_LOG2-1:0] r_idx;
  logic                r_pend;

  logic                r_pk_valid, r_pk_below;
  logic [BIN_W-1:0]    r_pk_bin;
  logic [PTS_LOG2-1:0] r_pk_index;
  logic [DATA_W-1:0]   r_pk_value, r_pk_left, r_pk_right;

  logic                w_accept, w_win_ok, w_last_addr;
  tag_t                w_tap;
  logic [DATA_W-1:0]   w_max, w_left, w_right;
  logic [PTS_LOG2-1:0] w_idx;
  logic                w_pend;

  // A start in the same cycle as the done pulse must not re-arm the sweep.
  assign w_accept    = (state == S_IDLE) && bus.start && !r_done;
  assign w_win_ok    = bus.win_lo <= bus.win_hi;
  assign w_last_addr = (r_pt == r_hi) && (r_bin == C_BIN_LAST);
  assign w_tap       = r_tag[RD_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // done is registered off DONE, so DRAIN lasts RD_LATENCY cycles.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (w_accept) state_nx = w_win_ok ? S_READ : S_DONE;
      S_READ:  if (w_last_addr) state_nx = S_DRAIN;
      S_DRAIN: if (r_cnt == C_DRAIN_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_max   = r_max;
    w_idx   = r_idx;
    w_left  = r_left;
    w_right = r_right;
    w_pend  = r_pend;
    if (w_tap.first) begin
      w_max   = bus.rd_data;
      w_idx   = w_tap.pt;
      w_left  = '0;
      w_right = '0;
      w_pend  = 1'b1;
    end else if (bus.rd_data > r_max) begin
      w_max   = bus.rd_data;
      w_idx   = w_tap.pt;
      w_left  = r_prev;
      w_right = '0;
      w_pend  = 1'b1;
    end else if (r_pend) begin
      w_right = bus.rd_data;
      w_pend  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lo <= '0; r_hi <= '0; r_pt <= '0; r_bin <= '0; r_thr <= '0;
      r_cnt <= '0; r_err <= 1'b0; r_done <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) r_tag[i] <= '0;
      r_max <= '0; r_left <= '0; r_right <= '0; r_prev <= '0;
      r_idx <= '0; r_pend <= 1'b0;
      r_pk_valid <= 1'b0; r_pk_below <= 1'b0; r_pk_bin <= '0;
      r_pk_index <= '0; r_pk_value <= '0; r_pk_left <= '0; r_pk_right <= '0;
    end else begin
      r_done <= (state == S_DONE);
      if (w_accept) begin
        r_lo  <= bus.win_lo;
        r_hi  <= bus.win_hi;
        r_thr <= bus.threshold;
        r_pt  <= bus.win_lo;
        r_bin <= '0;
        r_err <= !w_win_ok;
      end
      if (state == S_READ) begin
        if (r_pt == r_hi) begin
          r_pt  <= r_lo;
          r_bin <= r_bin + 1'b1;
        end else begin
          r_pt  <= r_pt + 1'b1;
        end
      end
      r_cnt <= (state == S_DRAIN) ? r_cnt + 1'b1 : '0;

      r_tag[0].vld   <= (state == S_READ);
      r_tag[0].bin   <= r_bin;
      r_tag[0].pt    <= r_pt;
      r_tag[0].first <= (r_pt == r_lo);
      r_tag[0].last  <= (r_pt == r_hi);
      for (int i = 1; i < RD_LATENCY; i++) r_tag[i] <= r_tag[i-1];

      if (w_tap.vld) begin
        r_max   <= w_max;
        r_idx   <= w_idx;
        r_left  <= w_left;
        r_right <= w_right;
        r_pend  <= w_pend;
        r_prev  <= bus.rd_data;
      end

      r_pk_valid <= w_tap.vld && w_tap.last;
      if (w_tap.vld && w_tap.last) begin
        r_pk_bin   <= w_tap.bin;
        r_pk_index <= w_idx;
        r_pk_value <= w_max;
        r_pk_left  <= w_left;
        r_pk_right <= w_right;
        r_pk_below <= w_max < r_thr;
      end
    end
  end

  // Outputs are forced low while reset is held so a mid-sweep reset is seen at once.
  assign bus.rd_en        = !rst && (state == S_READ);
  assign bus.rd_addr      = rst ? '0 : {r_bin, r_pt};
  assign bus.busy         = !rst && (state != S_IDLE);
  assign bus.done         = !rst && r_done;
  assign bus.cfg_err      = !rst && r_err;
  assign bus.pk_valid     = !rst && r_pk_valid;
  assign bus.pk_below_thr = !rst && r_pk_below;
  assign bus.pk_bin       = rst ? '0 : r_pk_bin;
  assign bus.pk_index     = rst ? '0 : r_pk_index;
  assign bus.pk_value     = rst ? '0 : r_pk_value;
  assign bus.pk_left      = rst ? '0 : r_pk_left;
  assign bus.pk_right     = rst ? '0 : r_pk_right;
endmodule
`default_nettype wire

// File: tb/tb_peak_search_multibin.sv
`default_nettype none
// =============================================================================
// tb_peak_search_multibin: directed and random sweeps against a reference model (rev 1.0)
// =============================================================================
module tb_peak_search_multibin;
  localparam int DW  = 32;
  localparam int NB  = 9;
  localparam int PL  = 10;
  localparam int BW  = 4;
  localparam int L   = 2;
  localparam int PTS = 1 << PL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [DW-1:0] mem [1 << (BW + PL)];
  logic [DW-1:0] rp  [L];
  logic [DW-1:0] e_val [NB];
  logic [DW-1:0] e_left [NB];
  logic [DW-1:0] e_right [NB];
  int            e_idx [NB];

  peak_search_multibin_if #(.DATA_W(DW), .PTS_LOG2(PL), .BIN_W(BW)) bus ();

  peak_search_multibin #(
    .DATA_W(DW), .NUM_BINS(NB), .PTS_LOG2(PL), .BIN_W(BW), .RD_LATENCY(L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    rp[0] <= mem[bus.rd_addr];
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign bus.rd_data = rp[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {bus.rd_en, bus.busy, bus.pk_valid, bus.done, bus.cfg_err, bus.pk_below_thr}, 0);
    chk({tag, "_data"}, bus.pk_value | bus.pk_left | bus.pk_right, 0);
    chk({tag, "_idx"}, {bus.rd_addr, bus.pk_index, bus.pk_bin}, 0);
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int i = 0; i < (1 << (BW + PL)); i++) mem[i] = v;
  endtask

  task automatic fill_rand(input int hi);
    for (int i = 0; i < (1 << (BW + PL)); i++) mem[i] = DW'($urandom_range(0, hi));
  endtask

  // Peak per bin straight from the window contents: first strict maximum and its neighbours.
  task automatic model(input int lo, input int hi);
    for (int b = 0; b < NB; b++) begin
      int best = lo;
      for (int p = lo + 1; p <= hi; p++)
        if (mem[b*PTS + p] > mem[b*PTS + best]) best = p;
      e_idx[b]   = best;
      e_val[b]   = mem[b*PTS + best];
      e_left[b]  = (best > lo) ? mem[b*PTS + best - 1] : '0;
      e_right[b] = (best < hi) ? mem[b*PTS + best + 1] : '0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && (bus.busy || bus.done); i++) @(negedge clk);
    chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic run_sweep(input int lo, input int hi, input logic [DW-1:0] thr,
                           input bit busy_start, input bit done_start);
    int  t0, w, k, rds, budget;
    bit  got_done;
    model(lo, hi);
    wait_idle();
    bus.win_lo = PL'(lo); bus.win_hi = PL'(hi); bus.threshold = thr;
    bus.start = 1'b1;
    t0 = cyc; w = hi - lo + 1; k = 0; rds = 0; got_done = 0;
    budget = NB * w + L + 20;
    for (int c = 0; c < budget && !got_done; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (busy_start && c == 2) begin
        bus.start = 1'b1; bus.win_lo = PL'(5); bus.win_hi = PL'(2);
      end
      if (bus.rd_en) rds++;
      if (bus.pk_valid) begin
        if (k < NB) begin
          chk("pk_bin", bus.pk_bin, k);
          chk("pk_index", bus.pk_index, e_idx[k]);
          chk("pk_value", bus.pk_value, e_val[k]);
          chk("pk_left", bus.pk_left, e_left[k]);
          chk("pk_right", bus.pk_right, e_right[k]);
          chk("pk_below", bus.pk_below_thr, e_val[k] < thr);
          chk("pk_cycle", cyc, t0 + (k + 1) * w + L + 1);
        end
        k++;
      end
      if (bus.done) begin
        got_done = 1;
        chk("done_cycle", cyc, t0 + NB * w + L + 2);
        chk("busy_at_done", bus.busy, 0);
        if (done_start) begin
          bus.start = 1'b1; bus.win_lo = PL'(0); bus.win_hi = PL'(0);
        end
      end
    end
    chk("done_seen", got_done, 1);
    chk("pk_count", k, NB);
    chk("rd_count", rds, NB * w);
    @(negedge clk);
    bus.start = 1'b0;
    chk("idle_after_done", {bus.busy, bus.rd_en}, 0);
    chk("cfg_err_clear", bus.cfg_err, 0);
  endtask

  task automatic run_err(input int lo, input int hi);
    int t0, rds, pks, dcyc;
    wait_idle();
    bus.win_lo = PL'(lo); bus.win_hi = PL'(hi); bus.threshold = '0;
    bus.start = 1'b1;
    t0 = cyc; rds = 0; pks = 0; dcyc = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.rd_en) rds++;
      if (bus.pk_valid) pks++;
      if (bus.done) dcyc = cyc;
    end
    chk("err_rd", rds, 0);
    chk("err_pk", pks, 0);
    chk("err_done_cycle", dcyc, t0 + 2);
    chk("err_cfg_err", bus.cfg_err, 1);
  endtask

  initial begin
    int lo, hi;
    logic [DW-1:0] thr;
    bus.start = 1'b0; bus.win_lo = '0; bus.win_hi = '0; bus.threshold = '0;
    fill_const(5);
    for (int i = 0; i < L; i++) rp[i] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int b = 0; b < NB; b++) mem[b*PTS + 100 + 10*b] = DW'(1000 + b);
    run_sweep(0, 1023, 0, 1'b1, 1'b1);

    fill_rand(100);
    for (int b = 0; b < NB; b++) begin
      mem[b*PTS + 300] = 900;
      mem[b*PTS + 700] = 800;
    end
    run_sweep(512, 1022, 850, 1'b0, 1'b0);

    fill_rand(40);
    mem[0*PTS + 12] = 50; mem[0*PTS + 15] = 50;
    mem[1*PTS + 10] = 60;
    mem[2*PTS + 20] = 70;
    run_sweep(10, 20, 50, 1'b0, 1'b0);
    run_sweep(7, 7, 20, 1'b0, 1'b0);

    run_err(30, 29);
    repeat (5) @(negedge clk);
    chk("cfg_err_hold", bus.cfg_err, 1);

    for (int r = 0; r < 5; r++) begin
      fill_rand(63);
      lo = $urandom_range(0, 1000);
      hi = lo + $urandom_range(0, 23);
      if (hi > 1023) hi = 1023;
      model(lo, hi);
      thr = r[0] ? e_val[0] : DW'($urandom_range(0, 70));
      run_sweep(lo, hi, thr, r[1], 1'b0);
    end

    fill_rand(1000);
    wait_idle();
    bus.win_lo = PL'(0); bus.win_hi = PL'(99); bus.threshold = 500;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (349) @(negedge clk);
    chk("mid_bin3_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk_zero("rst_same_cycle");
    repeat (3) begin
      @(negedge clk);
      chk_zero("rst_hold");
    end
    rst = 1'b0;
    for (int c = 0; c < L + 6; c++) begin
      @(negedge clk);
      chk("no_stale", {bus.pk_valid, bus.done, bus.busy, bus.rd_en}, 0);
    end
    run_sweep(0, 99, 500, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
